// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter.
// Holds the arbiter state encoding, the bus command payload layout
// and the fixed-priority decision helper used in the idle state.
package mem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_bus_cmd_t;

  // Fetch wins when it is alone, or when it has lost too many conflicts.
  function automatic logic pick_fetch(input logic i_req, input logic d_req,
                                      input logic starved);
    return i_req && (!d_req || starved);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single external memory bus between instruction
// fetch and the data-memory stage, one outstanding transaction at a time.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_req/i_addr/i_gnt                 fetch request, grant is combinational
//   i_rvalid/i_rdata                   registered fetch completion
//   i_flash                            discard the in-flight fetch response
//   d_req/d_we/d_be/d_addr/d_wdata     data request, d_gnt combinational
//   d_rvalid/d_rdata                   registered data completion
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata  registered bus command
//   bus_ack/bus_rdata                  bus completion and read data
//   i_busy/d_busy                      request pending but not granted
// The captured command is sized by the package bus widths.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = MEM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                i_flash,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                i_busy,
  output logic                d_busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               drop_i_q, drop_i_d;
  logic               bus_req_q, bus_req_d;
  mem_bus_cmd_t       bus_cmd_q, bus_cmd_d;
  logic               i_rvalid_q, i_rvalid_d;
  logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

  logic idle, gnt_i, gnt_d, ack_v;

  // Grant decision; suppressed while reset is asserted so all outputs read 0.
  always_comb begin
    idle  = rst_n && (state_q == ARB_IDLE);
    gnt_i = idle && pick_fetch(i_req, d_req, starve_cnt_q == CNT_MAX);
    gnt_d = idle && d_req && !gnt_i;
    // An ack only counts while a request is actually on the bus.
    ack_v = bus_ack && bus_req_q;
  end

  // Next-state, command capture and completion logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_i_d     = drop_i_q;
    bus_req_d    = bus_req_q;
    bus_cmd_d    = bus_cmd_q;
    i_rvalid_d   = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_i) begin
          state_d         = ARB_I;
          bus_req_d       = 1'b1;
          bus_cmd_d.we    = 1'b0;
          bus_cmd_d.be    = '1;
          bus_cmd_d.addr  = MEM_ADDR_W'(i_addr);
          bus_cmd_d.wdata = '0;
          starve_cnt_d    = '0;
        end else if (gnt_d) begin
          state_d         = ARB_D;
          bus_req_d       = 1'b1;
          bus_cmd_d.we    = d_we;
          bus_cmd_d.be    = MEM_BE_W'(d_be);
          bus_cmd_d.addr  = MEM_ADDR_W'(d_addr);
          bus_cmd_d.wdata = MEM_DATA_W'(d_wdata);
          // Data won a conflict: count toward fetch starvation, saturating.
          if (i_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      ARB_I: begin
        if (ack_v) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          drop_i_d  = 1'b0;
          // A flush in the ack cycle discards the response as well.
          if (!(drop_i_q || i_flash)) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = bus_rdata;
          end
        end else if (i_flash) begin
          drop_i_d = 1'b1;
        end
      end
      ARB_D: begin
        if (ack_v) begin
          state_d    = ARB_IDLE;
          bus_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = bus_cmd_q.we ? '0 : bus_rdata;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      drop_i_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_cmd_q    <= '0;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_i_q     <= drop_i_d;
      bus_req_q    <= bus_req_d;
      bus_cmd_q    <= bus_cmd_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_gnt     = gnt_i;
  assign d_gnt     = gnt_d;
  assign i_busy    = rst_n && i_req && !gnt_i;
  assign d_busy    = rst_n && d_req && !gnt_d;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_cmd_q.we;
  assign bus_be    = BE_W'(bus_cmd_q.be);
  assign bus_addr  = ADDR_W'(bus_cmd_q.addr);
  assign bus_wdata = DATA_W'(bus_cmd_q.wdata);
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk, rst_n;
  logic        i_req, i_gnt, i_rvalid, i_flash;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        i_busy, d_busy;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_flash(i_flash),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .i_busy(i_busy), .d_busy(d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data) and what it issued.
  int          m_owner, m_starve;
  bit          m_drop, m_bus_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  bit          e_irv, e_drv;
  logic [31:0] e_ird, e_drd;
  bit          last_gi, last_gd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_drop = 0; m_bus_req = 0; m_we = 0;
    m_be = '0; m_addr = '0; m_wdata = '0;
    e_irv = 0; e_drv = 0; e_ird = '0; e_drd = '0;
    last_gi = 0; last_gd = 0;
  endtask

  // Compare outputs against the model, then advance it across the next edge.
  task automatic model_cycle();
    bit gi, gd;
    if (!rst_n) begin
      chk("rst_i_gnt", i_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
      chk("rst_i_busy", i_busy, 0);   chk("rst_d_busy", d_busy, 0);
      chk("rst_bus_req", bus_req, 0); chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_be", bus_be, 0);   chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_i_rvalid", i_rvalid, 0); chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rvalid", d_rvalid, 0); chk("rst_d_rdata", d_rdata, 0);
      model_reset();
      return;
    end
    gi = (m_owner == 0) && i_req && (!d_req || m_starve == LIMIT);
    gd = (m_owner == 0) && d_req && !gi;
    chk("i_gnt", i_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    chk("i_busy", i_busy, i_req && !gi);
    chk("d_busy", d_busy, d_req && !gd);
    chk("bus_req", bus_req, m_bus_req);
    if (m_bus_req) begin
      chk("bus_we", bus_we, m_we);
      chk("bus_addr", bus_addr, m_addr);
      if (m_owner == 2) begin
        chk("bus_be", bus_be, m_be);
        chk("bus_wdata", bus_wdata, m_wdata);
      end
    end
    chk("i_rvalid", i_rvalid, e_irv);
    if (e_irv) chk("i_rdata", i_rdata, e_ird);
    chk("d_rvalid", d_rvalid, e_drv);
    if (e_drv) chk("d_rdata", d_rdata, e_drd);

    e_irv = 0; e_drv = 0;
    if (m_bus_req && bus_ack) begin
      if (m_owner == 1) begin
        if (!(m_drop || i_flash)) begin e_irv = 1; e_ird = bus_rdata; end
        m_drop = 0;
      end else begin
        e_drv = 1; e_drd = m_we ? 32'h0 : bus_rdata;
      end
      m_owner = 0; m_bus_req = 0;
    end else if (m_owner == 1 && i_flash) begin
      m_drop = 1;
    end
    if (gi) begin
      m_owner = 1; m_bus_req = 1; m_we = 0; m_addr = i_addr; m_starve = 0;
    end else if (gd) begin
      m_owner = 2; m_bus_req = 1; m_we = d_we; m_be = d_be;
      m_addr = d_addr; m_wdata = d_wdata;
      if (i_req && m_starve < LIMIT) m_starve++;
    end
    last_gi = gi; last_gd = gd;
  endtask

  // One clock: model check at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 0; i_req = 0; i_addr = '0; i_flash = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    bus_ack = 0; bus_rdata = '0;
    tick(); tick();
    rst_n = 1;

    // Lone fetch, ack in cycle 3.
    i_req = 1; i_addr = 32'h1000; settle();
    chk("lone_gnt_c0", i_gnt, 1);
    tick(); i_req = 0; settle();
    chk("lone_busreq_c1", bus_req, 1); chk("lone_addr_c1", bus_addr, 32'h1000);
    tick(); settle(); chk("lone_busreq_c2", bus_req, 1);
    tick(); bus_ack = 1; bus_rdata = 32'hDEADBEEF; settle();
    chk("lone_busreq_c3", bus_req, 1);
    tick(); bus_ack = 0; settle();
    chk("lone_rvalid_c4", i_rvalid, 1); chk("lone_rdata_c4", i_rdata, 32'hDEADBEEF);
    chk("lone_busreq_c4", bus_req, 0);
    tick(); settle(); chk("lone_rvalid_c5", i_rvalid, 0);

    // Conflict with immediate acks: four data wins, then fetch.
    i_req = 1; i_addr = 32'h1100; d_req = 1; d_we = 0; d_addr = 32'h2000;
    bus_ack = 1; bus_rdata = 32'h0BAD0BAD;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("conf_d_gnt", d_gnt, (k % 2 == 0) && k < 8);
      chk("conf_i_gnt", i_gnt, k == 8);
      if (k == 8) chk("conf_starve_sat", dut.starve_cnt_q, LIMIT);
      if (k == 9) begin
        chk("conf_starve_clr", dut.starve_cnt_q, 0);
        i_req = 0; d_req = 0;
      end
      tick();
    end
    bus_ack = 0; tick();

    // Data write.
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 32'h12345678;
    settle(); chk("wr_gnt", d_gnt, 1);
    tick(); d_req = 0; bus_ack = 1; bus_rdata = 32'hCAFEF00D; settle();
    chk("wr_bus_we", bus_we, 1);          chk("wr_bus_be", bus_be, 4'hF);
    chk("wr_bus_addr", bus_addr, 32'h3000); chk("wr_bus_wdata", bus_wdata, 32'h12345678);
    tick(); bus_ack = 0; settle();
    chk("wr_rvalid", d_rvalid, 1); chk("wr_rdata_zero", d_rdata, 0);
    tick();

    // Flush in cycle 2, ack in cycle 4, queued data granted in cycle 5.
    i_req = 1; i_addr = 32'h4000; d_we = 0; settle(); chk("fl_gnt", i_gnt, 1);
    tick(); i_req = 0;
    tick(); i_flash = 1;
    tick(); i_flash = 0; d_req = 1; d_addr = 32'h5000; settle();
    chk("fl_d_busy", d_busy, 1);
    tick(); bus_ack = 1; bus_rdata = 32'h11111111;
    tick(); bus_ack = 0; settle();
    chk("fl_no_rvalid", i_rvalid, 0); chk("fl_d_gnt_c5", d_gnt, 1);
    tick(); d_req = 0; bus_ack = 1; bus_rdata = 32'h22222222;
    tick(); bus_ack = 0; settle();
    chk("fl_d_rvalid", d_rvalid, 1); chk("fl_d_rdata", d_rdata, 32'h22222222);
    tick();

    // Busy while fetch waits 5 cycles for its ack.
    i_req = 1; i_addr = 32'h6000; settle(); chk("busy_i_gnt", i_gnt, 1);
    tick(); i_req = 0; d_req = 1; d_addr = 32'h7000;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin bus_ack = 1; bus_rdata = 32'hABCD0001; end
      settle(); chk("busy_d_busy", d_busy, 1);
      tick();
    end
    bus_ack = 0; settle();
    chk("busy_d_gnt", d_gnt, 1); chk("busy_d_busy_off", d_busy, 0);
    chk("busy_i_rvalid", i_rvalid, 1); chk("busy_i_rdata", i_rdata, 32'hABCD0001);
    tick();

    // Reset while the data transaction is on the bus.
    rst_n = 0; settle();
    chk("rstmid_bus_req", bus_req, 0); chk("rstmid_d_gnt", d_gnt, 0);
    chk("rstmid_d_rvalid", d_rvalid, 0);
    tick();
    rst_n = 1; d_req = 0; i_req = 1; i_addr = 32'h8000; settle();
    chk("rstmid_i_gnt", i_gnt, 1);
    tick(); i_req = 0; bus_ack = 1; bus_rdata = 32'h8888;
    tick(); bus_ack = 0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (i_req && last_gi) i_req = 0;
      else if (i_req && $urandom_range(19) == 0) i_req = 0;
      else if (!i_req && $urandom_range(1) == 1) begin i_req = 1; i_addr = $urandom; end
      if (d_req && last_gd) d_req = 0;
      else if (d_req && $urandom_range(19) == 0) d_req = 0;
      else if (!d_req && $urandom_range(1) == 1) begin
        d_req = 1; d_we = 1'($urandom_range(1)); d_be = 4'($urandom_range(15));
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_flash   = ($urandom_range(7) == 0);
      bus_ack   = ($urandom_range(2) == 0);
      bus_rdata = $urandom;
      tick();
    end

    i_req = 0; d_req = 0; i_flash = 0; bus_ack = 1;
    tick(); tick(); bus_ack = 0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
